cam_line_udp_sched: RTL and testbench
=====================================

Name: cam_line_udp_sched

Overview:
- Scheduler between the camera line capture buffer and the UDP transmit path inside fpga_core.
- The line buffer is a 2-bank BRAM. The capture side signals each completed line together with its bank and its length.
- The block queues completed lines and splits each into chunks of at most MAX_CHUNK bytes. For every chunk it issues one UDP header request, then streams a 6-byte sub-header followed by the payload bytes read from the buffer.
- When the UDP path falls behind, lines are dropped and counted.

Parameters:
- ADDR_W, 11, line buffer address width per bank (max line 2^ADDR_W bytes).
- MAX_CHUNK, 1024, maximum payload bytes per UDP packet, excluding the sub-header; range 1..2^ADDR_W.
- SUBHDR_LEN, 6, sub-header byte count; fixed, not user-changeable.

Ports:
- clk, in, 1, core clock (100 MHz).
- rst, in, 1, synchronous active-high reset.
- frame_start, in, 1, one-cycle pulse on VSYNC, already synchronised to clk.
- line_done, in, 1, one-cycle pulse: a line has been fully written.
- line_bank, in, 1, bank written, valid with line_done.
- line_len, in, ADDR_W+1, line byte count, valid with line_done; 0 is legal.
- buf_rd_bank, out, 1, BRAM read bank.
- buf_rd_addr, out, ADDR_W, BRAM read address.
- buf_rd_data, in, 8, BRAM data, exactly 1 cycle after address.
- hdr_valid, out, 1, UDP header request.
- hdr_ready, in, 1, header accepted.
- hdr_length, out, 16, UDP payload length = SUBHDR_LEN + chunk bytes.
- tx_tdata, out, 8, payload stream data.
- tx_tvalid, out, 1, payload stream valid.
- tx_tready, in, 1, payload stream ready.
- tx_tlast, out, 1, last byte of the packet.
- bank_free, out, 2, one bit per bank: set = bank may be overwritten by capture.
- drop_cnt, out, 16, lines dropped; saturates at 0xFFFF.
- busy, out, 1, high when not in IDLE.

Behaviour:
- Reset:
  - hdr_valid=0, tx_tvalid=0, tx_tlast=0, busy=0, bank_free=2'b11, drop_cnt=0.
  - frame_id=0, line_id=0, queue empty, state IDLE.
  - Reset mid-packet abandons the packet immediately; no tlast is emitted.
- Counters:
  - frame_start increments frame_id (16-bit, wraps) and clears line_id.
  - Each accepted line_done gets the current line_id, then line_id increments (16-bit, wraps).
  - A dropped line also consumes a line_id, so line gaps are visible to the receiver.
  - frame_start and line_done in the same cycle: the line is tagged with the old frame_id and line_id; the new frame takes effect from the next cycle.
- Queue:
  - 2-entry FIFO of {bank, len, frame_id, line_id}.
  - line_done with a non-full queue: push the entry and clear bank_free[bank].
  - line_done with a full queue: do not push, increment drop_cnt (saturating), leave bank_free unchanged.
  - Push and pop in the same cycle are both honoured.
- State machine:
  - IDLE: when the queue is non-empty, load the head and set offset=0.
    - len=0 goes to RELEASE directly; no packet is sent.
    - Otherwise go to HDR.
  - HDR: hdr_valid=1 and hdr_length=6+min(MAX_CHUNK, len−offset), held stable until hdr_ready. The transfer happens on a valid&&ready cycle; then go to SUB.
  - SUB: emit 6 big-endian bytes {frame_id, line_id, offset}. Each byte advances only on tvalid&&tready. Then go to PAY.
  - PAY: emit chunk bytes from buf_rd_addr = offset+i.
    - tx_tlast is set on the last byte of the chunk.
    - On the tlast handshake: offset += chunk. If offset==len go to RELEASE, else go to HDR.
  - RELEASE: set bank_free[bank]=1, pop the queue, go to IDLE. One cycle.
- Datapath rules:
  - BRAM latency is 1 cycle. tdata must remain correct under arbitrary tready stalls, which requires a prefetch register plus a skid register.
  - Bubbles in tvalid are permitted. Throughput must be ≥1 byte/cycle sustained when tready=1.
  - tdata, tvalid and tlast must be stable while tvalid&&!tready.
- The block never asserts hdr_valid and tx_tvalid for the same packet out of order: the header is accepted before the first payload byte.
- Arithmetic: offset and len are ADDR_W+1 bits. Chunk = min(MAX_CHUNK, len−offset). hdr_length is zero-extended to 16 bits.

Decomposition:
- Package cam_udp_pkg holds:
  - SUBHDR_LEN;
  - the state enum (IDLE, HDR, SUB, PAY, RELEASE);
  - the queue-entry struct {bank, len, frame_id, line_id}.
- Sub-module bram_axis_reader: takes a start address and count, drives the BRAM read port, and produces AXI-stream bytes with tlast. It owns the 1-cycle-latency prefetch and skid logic.

Test Plan:
- Single line, len=100, tready=1 → one hdr_length=106; stream 00 00 00 00 00 00 then bytes 0..99; tlast on byte 99; bank_free returns to 11.
- len=2500, MAX_CHUNK=1024 → three packets with hdr_length 1030, 1030, 458 and offsets 0, 1024, 2048; single tlast per packet.
- Random tready (50%) and hdr_ready delayed 7 cycles, len=300 → byte sequence identical to the tready=1 case; no data change while stalled.
- Three line_done pulses back-to-back while the first is stalled on hdr_ready=0 → drop_cnt=1; transmitted line_ids are 0 and 1; the next accepted line carries line_id=3.
- frame_start, then two lines; frame_start coincident with line_done → the first two lines carry frame_id=1 with line_ids 0 and 1; the coincident line carries frame_id=1, line_id=2; the next carries frame_id=2, line_id=0.
- len=0 line, and rst asserted mid-PAY → no packet for len=0, bank freed; after rst all outputs are at reset values and the next line starts with frame_id=0.

Source files
------------

// File: rtl/cam_line_udp_sched_pkg.sv
// Shared types for the camera line -> UDP scheduler: FSM states, line queue
// entry layout and the sub-header byte selector.
package cam_udp_pkg;

    localparam int SUBHDR_LEN = 6;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SUB,
        PAY,
        RELEASE
    } state_t;

    // One completed line waiting for transmission. len is kept at 16 bits so
    // the struct does not depend on the line buffer address width.
    typedef struct packed {
        logic        bank;
        logic [15:0] len;
        logic [15:0] frame_id;
        logic [15:0] line_id;
    } q_entry_t;

    // Big-endian sub-header {frame_id, line_id, offset}, byte idx 0..5.
    function automatic logic [7:0] subhdr_byte(input logic [15:0] fid,
                                               input logic [15:0] lid,
                                               input logic [15:0] off,
                                               input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = fid[15:8];
            3'd1:    b = fid[7:0];
            3'd2:    b = lid[15:8];
            3'd3:    b = lid[7:0];
            3'd4:    b = off[15:8];
            3'd5:    b = off[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cam_line_udp_sched_if.sv
// UDP-side handshakes of the scheduler: header request channel plus the
// byte-wide payload stream.
interface cam_line_udp_sched_if;

    logic        hdr_valid;
    logic        hdr_ready;
    logic [15:0] hdr_length;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic        tx_tlast;

    modport master (
        output hdr_valid, hdr_length, tx_tdata, tx_tvalid, tx_tlast,
        input  hdr_ready, tx_tready
    );

    modport slave (
        input  hdr_valid, hdr_length, tx_tdata, tx_tvalid, tx_tlast,
        output hdr_ready, tx_tready
    );

endinterface

// File: rtl/cam_line_udp_sched_bram_axis_reader.sv
// Turns a (start address, byte count) request into a byte stream read from a
// 1-cycle-latency BRAM. An output register plus a skid register absorb the
// read that is already in flight when the consumer stalls, so data stays
// correct under any tready pattern and runs at one byte per cycle otherwise.
module bram_axis_reader #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   start_cnt,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [7:0]        buf_rd_data,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_left;
    logic              rd_vld_p1;
    logic              rd_last_p1;
    logic              out_vld, out_last;
    logic [7:0]        out_data;
    logic              skid_vld, skid_last;
    logic [7:0]        skid_data;
    logic              pop;
    logic              issue;
    logic [1:0]        fill;

    assign pop  = out_vld && m_tready;
    // Slots that stay occupied after this cycle; a new read may only be
    // issued if its byte is guaranteed a slot when it returns.
    assign fill = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_vld_p1} - {1'b0, pop};
    assign issue = !start && (rd_left != '0) && (fill <= 2'd1);

    assign buf_rd_addr = rd_addr;
    assign m_tdata     = out_data;
    assign m_tvalid    = out_vld;
    assign m_tlast     = out_vld && out_last;

    // Control: outstanding byte count, in-flight read flag, slot occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_left   <= '0;
            rd_vld_p1 <= 1'b0;
            out_vld   <= 1'b0;
            skid_vld  <= 1'b0;
        end else begin
            rd_vld_p1 <= issue;
            if (start)
                rd_left <= start_cnt;
            else if (issue)
                rd_left <= rd_left - 1'b1;
            if (!out_vld || pop) begin
                if (skid_vld) begin
                    out_vld  <= 1'b1;
                    skid_vld <= rd_vld_p1;
                end else begin
                    out_vld  <= rd_vld_p1;
                    skid_vld <= 1'b0;
                end
            end else if (rd_vld_p1) begin
                skid_vld <= 1'b1;
            end
        end
    end

    // Data: read address, returning byte and its last flag into out/skid
    always_ff @(posedge clk) begin
        if (start)
            rd_addr <= start_addr;
        else if (issue)
            rd_addr <= rd_addr + 1'b1;
        rd_last_p1 <= (rd_left == CNT_ONE);
        if (!out_vld || pop) begin
            if (skid_vld) begin
                out_data  <= skid_data;
                out_last  <= skid_last;
                skid_data <= buf_rd_data;
                skid_last <= rd_last_p1;
            end else begin
                out_data  <= buf_rd_data;
                out_last  <= rd_last_p1;
            end
        end else if (rd_vld_p1) begin
            skid_data <= buf_rd_data;
            skid_last <= rd_last_p1;
        end
    end

endmodule

// File: rtl/cam_line_udp_sched.sv
// Camera line -> UDP scheduler. Queues completed lines (2 deep), splits each
// into chunks of at most MAX_CHUNK bytes and for every chunk issues a UDP
// header request, a 6-byte {frame_id, line_id, offset} sub-header and the
// payload read from the 2-bank line buffer. Lines arriving on a full queue
// are dropped and counted; dropped lines still consume a line_id.
module cam_line_udp_sched
    import cam_udp_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int MAX_CHUNK = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 line_done,
    input  logic                 line_bank,
    input  logic [ADDR_W:0]      line_len,
    output logic                 buf_rd_bank,
    output logic [ADDR_W-1:0]    buf_rd_addr,
    input  logic [7:0]           buf_rd_data,
    cam_line_udp_sched_if.master tx,
    output logic [1:0]           bank_free,
    output logic [15:0]          drop_cnt,
    output logic                 busy
);

    localparam logic [ADDR_W:0] CHUNK_MAX = MAX_CHUNK[ADDR_W:0];

    state_t          state, state_n;
    logic [15:0]     frame_id, line_id;

    q_entry_t        q_mem [2];
    q_entry_t        head, new_entry, cur;
    logic            q_wr_ptr, q_rd_ptr;
    logic [1:0]      q_cnt;
    logic            q_full, q_push, q_pop;

    logic [ADDR_W:0] offset;
    logic [2:0]      sub_idx;
    logic [15:0]     len_rem;
    logic [ADDR_W:0] chunk;
    logic            last_chunk;

    logic            rd_start;
    logic [7:0]      rd_tdata;
    logic            rd_tvalid, rd_tlast, rd_tready;
    logic            pay_end;

    assign q_full = (q_cnt == 2'd2);
    assign q_push = line_done && !q_full;
    assign q_pop  = (state == RELEASE);
    assign head   = q_mem[q_rd_ptr];

    assign new_entry.bank     = line_bank;
    assign new_entry.len      = 16'(line_len);
    assign new_entry.frame_id = frame_id;
    assign new_entry.line_id  = line_id;

    assign len_rem    = cur.len - 16'(offset);
    assign chunk      = (len_rem > 16'(MAX_CHUNK)) ? CHUNK_MAX : len_rem[ADDR_W:0];
    assign last_chunk = ((16'(offset) + 16'(chunk)) == cur.len);

    assign tx.hdr_length = 16'(SUBHDR_LEN) + 16'(chunk);
    assign buf_rd_bank   = cur.bank;
    assign busy          = (state != IDLE);
    assign rd_tready     = tx.tx_tready && (state == PAY);
    assign pay_end       = (state == PAY) && rd_tvalid && tx.tx_tready && rd_tlast;

    // Frame/line numbering; a coincident line_done is tagged with the old ids
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_id <= '0;
            line_id  <= '0;
        end else if (frame_start) begin
            frame_id <= frame_id + 16'd1;
            line_id  <= '0;
        end else if (line_done) begin
            line_id  <= line_id + 16'd1;
        end
    end

    // Queue pointers/occupancy, bank ownership and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr_ptr  <= 1'b0;
            q_rd_ptr  <= 1'b0;
            q_cnt     <= '0;
            bank_free <= 2'b11;
            drop_cnt  <= '0;
        end else begin
            if (q_push)
                q_wr_ptr <= ~q_wr_ptr;
            if (q_pop)
                q_rd_ptr <= ~q_rd_ptr;
            q_cnt <= q_cnt + {1'b0, q_push} - {1'b0, q_pop};
            if (q_pop)
                bank_free[cur.bank] <= 1'b1;
            if (q_push)
                bank_free[line_bank] <= 1'b0;
            if (line_done && q_full && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (q_push)
            q_mem[q_wr_ptr] <= new_entry;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Per-line working registers: head capture, sub-header index, offset
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                cur    <= head;
                offset <= '0;
            end
            HDR:     sub_idx <= '0;
            SUB:     if (tx.tx_tready) sub_idx <= sub_idx + 3'd1;
            PAY:     if (pay_end) offset <= offset + chunk;
            default: ;
        endcase
    end

    // FSM next state and the multiplexed header/stream outputs
    always_comb begin
        state_n      = state;
        tx.hdr_valid = 1'b0;
        tx.tx_tvalid = 1'b0;
        tx.tx_tdata  = 8'h00;
        tx.tx_tlast  = 1'b0;
        rd_start     = 1'b0;
        case (state)
            IDLE: begin
                if (q_cnt != 2'd0)
                    state_n = (head.len == 16'd0) ? RELEASE : HDR;
            end
            HDR: begin
                tx.hdr_valid = 1'b1;
                if (tx.hdr_ready)
                    state_n = SUB;
            end
            SUB: begin
                tx.tx_tvalid = 1'b1;
                tx.tx_tdata  = subhdr_byte(cur.frame_id, cur.line_id, 16'(offset), sub_idx);
                if (tx.tx_tready && (sub_idx == 3'd5)) begin
                    state_n  = PAY;
                    rd_start = 1'b1;
                end
            end
            PAY: begin
                tx.tx_tvalid = rd_tvalid;
                tx.tx_tdata  = rd_tdata;
                tx.tx_tlast  = rd_tlast;
                if (pay_end)
                    state_n = last_chunk ? RELEASE : HDR;
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    bram_axis_reader #(
        .ADDR_W (ADDR_W)
    ) u_reader (
        .clk         (clk),
        .rst         (rst),
        .start       (rd_start),
        .start_addr  (offset[ADDR_W-1:0]),
        .start_cnt   (chunk),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .m_tdata     (rd_tdata),
        .m_tvalid    (rd_tvalid),
        .m_tlast     (rd_tlast),
        .m_tready    (rd_tready)
    );

endmodule

// File: tb/tb_cam_line_udp_sched.sv
// Scoreboard bench for cam_line_udp_sched: each issued line pushes its
// expected headers and stream bytes; a negedge monitor pops and compares.
module tb_cam_line_udp_sched;

    localparam int ADDR_W    = 12;
    localparam int MAX_CHUNK = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start, line_done, line_bank;
    logic [ADDR_W:0]   line_len;
    logic              buf_rd_bank;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [7:0]        buf_rd_data;
    logic [1:0]        bank_free;
    logic [15:0]       drop_cnt;
    logic              busy;

    cam_line_udp_sched_if tx();

    cam_line_udp_sched #(
        .ADDR_W    (ADDR_W),
        .MAX_CHUNK (MAX_CHUNK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .line_done   (line_done),
        .line_bank   (line_bank),
        .line_len    (line_len),
        .buf_rd_bank (buf_rd_bank),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .tx          (tx),
        .bank_free   (bank_free),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         exp_hdr[$];
    logic [8:0] exp_byte[$];
    int         hdr_log[$];
    int         hdr_acc = 0;
    int         pkt_done = 0;
    int         nbytes = 0;
    int         tr_mode = 0;
    int         hr_mode = 0;
    int         hv_cnt = 0;

    function automatic logic [7:0] mem_byte(input logic b, input int a);
        return 8'(a) ^ (b ? 8'h5A : 8'h00);
    endfunction

    function automatic int log_at(input int i);
        if (i < hdr_log.size())
            return hdr_log[i];
        return -1;
    endfunction

    // Line buffer model: 1-cycle read latency
    always @(posedge clk)
        buf_rd_data <= mem_byte(buf_rd_bank, int'(buf_rd_addr));

    // UDP-side ready drivers: always / random 50% / hold-off
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       tx.tx_tready = 1'b1;
            1:       tx.tx_tready = ($urandom_range(0, 1) == 1);
            default: tx.tx_tready = 1'b0;
        endcase
        if (tx.hdr_valid) hv_cnt++;
        else              hv_cnt = 0;
        case (hr_mode)
            0:       tx.hdr_ready = 1'b1;
            1:       tx.hdr_ready = (hv_cnt >= 7);
            default: tx.hdr_ready = 1'b0;
        endcase
    end

    // Monitor: sample between edges, compare against the scoreboard
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;
    always @(negedge clk) begin
        int         e;
        logic [8:0] eb;
        if (rst) begin
            exp_hdr.delete();
            exp_byte.delete();
            stall_prev = 1'b0;
            pkt_done   = hdr_acc;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(tx.tx_tvalid && tx.tx_tdata == stall_data && tx.tx_tlast == stall_last)) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b d=%02h l=%0b required v=1 d=%02h l=%0b",
                             tx.tx_tvalid, tx.tx_tdata, tx.tx_tlast, stall_data, stall_last);
                end
            end
            stall_prev = tx.tx_tvalid && !tx.tx_tready;
            stall_data = tx.tx_tdata;
            stall_last = tx.tx_tlast;
            if (tx.hdr_valid && tx.hdr_ready) begin
                hdr_acc++;
                hdr_log.push_back(int'(tx.hdr_length));
                checks++;
                if (exp_hdr.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_unexpected got %0d required none", tx.hdr_length);
                end else begin
                    e = exp_hdr.pop_front();
                    if (e != int'(tx.hdr_length)) begin
                        errors++;
                        $display("FAIL hdr_length got %0d required %0d", tx.hdr_length, e);
                    end
                end
            end
            if (tx.tx_tvalid && tx.tx_tready) begin
                nbytes++;
                checks++;
                if (hdr_acc <= pkt_done) begin
                    errors++;
                    $display("FAIL hdr_order byte before header got hdr_acc=%0d required >%0d", hdr_acc, pkt_done);
                end
                checks++;
                if (exp_byte.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected got %02h last=%0b required none", tx.tx_tdata, tx.tx_tlast);
                end else begin
                    eb = exp_byte.pop_front();
                    if (eb[7:0] != tx.tx_tdata || eb[8] != tx.tx_tlast) begin
                        errors++;
                        $display("FAIL stream_byte got %02h last=%0b required %02h last=%0b",
                                 tx.tx_tdata, tx.tx_tlast, eb[7:0], eb[8]);
                    end
                end
                if (tx.tx_tlast) pkt_done++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    // Expected packets for one line: header, 6 sub-header bytes, payload
    task automatic push_line(input logic b, input int len, input int fid, input int lid);
        int   off = 0;
        int   ch;
        logic lst;
        while (off < len) begin
            ch = (len - off > MAX_CHUNK) ? MAX_CHUNK : len - off;
            exp_hdr.push_back(6 + ch);
            exp_byte.push_back({1'b0, 8'(fid >> 8)});
            exp_byte.push_back({1'b0, 8'(fid)});
            exp_byte.push_back({1'b0, 8'(lid >> 8)});
            exp_byte.push_back({1'b0, 8'(lid)});
            exp_byte.push_back({1'b0, 8'(off >> 8)});
            exp_byte.push_back({1'b0, 8'(off)});
            for (int i = 0; i < ch; i++) begin
                lst = (i == ch - 1);
                exp_byte.push_back({lst, mem_byte(b, off + i)});
            end
            off += ch;
        end
    endtask

    task automatic do_line(input logic b, input int len);
        line_done = 1'b1;
        line_bank = b;
        line_len  = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        line_done = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        repeat (2) @(posedge clk);
        while ((busy || bank_free != 2'b11 || exp_byte.size() != 0 || exp_hdr.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout got %0d cycles required <%0d", name, n, budget);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hdr_valid"}, 32'(tx.hdr_valid), 0);
        chk({tag, "_tvalid"},    32'(tx.tx_tvalid), 0);
        chk({tag, "_tlast"},     32'(tx.tx_tlast),  0);
        chk({tag, "_busy"},      32'(busy),         0);
        chk({tag, "_bank_free"}, 32'(bank_free),    3);
        chk({tag, "_drop_cnt"},  32'(drop_cnt),     0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst = 1'b1; frame_start = 1'b0; line_done = 1'b0; line_bank = 1'b0; line_len = '0;
        repeat (3) @(posedge clk); #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single short line, free-running ready
        hdr_log.delete();
        push_line(1'b0, 100, 0, 0);
        do_line(1'b0, 100);
        wait_done("t1", 5000);
        chk("t1_bank_free", 32'(bank_free), 3);
        chk("t1_hdr_count", 32'(hdr_log.size()), 1);
        chk("t1_hdr_len", 32'(log_at(0)), 106);

        // Long line split into three chunks
        hdr_log.delete();
        push_line(1'b1, 2500, 0, 1);
        do_line(1'b1, 2500);
        wait_done("t2", 10000);
        chk("t2_hdr_count", 32'(hdr_log.size()), 3);
        chk("t2_hdr0", 32'(log_at(0)), 1030);
        chk("t2_hdr1", 32'(log_at(1)), 1030);
        chk("t2_hdr2", 32'(log_at(2)), 458);

        // Random tready and delayed hdr_ready
        hdr_log.delete();
        tr_mode = 1; hr_mode = 1;
        push_line(1'b0, 300, 0, 2);
        do_line(1'b0, 300);
        wait_done("t3", 10000);
        tr_mode = 0; hr_mode = 0;
        chk("t3_hdr_len", 32'(log_at(0)), 306);

        // Overflow: three back-to-back lines while header is held off
        pulse_frame();
        hr_mode = 2;
        push_line(1'b1, 20, 1, 0);
        push_line(1'b0, 20, 1, 1);
        do_line(1'b1, 20);
        do_line(1'b0, 20);
        do_line(1'b1, 20);
        chk("t4_drop_cnt", 32'(drop_cnt), 1);
        chk("t4_bank_free_held", 32'(bank_free), 0);
        chk("t4_busy", 32'(busy), 1);
        hr_mode = 0;
        wait_done("t4", 5000);
        push_line(1'b0, 10, 1, 3);
        do_line(1'b0, 10);
        wait_done("t4b", 5000);
        chk("t4_drop_cnt_after", 32'(drop_cnt), 1);

        // Frame numbering, including frame_start coincident with line_done
        pulse_frame();
        push_line(1'b0, 5, 2, 0);
        do_line(1'b0, 5);
        wait_done("t5a", 2000);
        push_line(1'b1, 5, 2, 1);
        do_line(1'b1, 5);
        wait_done("t5b", 2000);
        push_line(1'b0, 5, 2, 2);
        frame_start = 1'b1;
        do_line(1'b0, 5);
        frame_start = 1'b0;
        wait_done("t5c", 2000);
        push_line(1'b1, 5, 3, 0);
        do_line(1'b1, 5);
        wait_done("t5d", 2000);

        // Zero-length line: bank taken then released, no packet
        hdr_log.delete();
        do_line(1'b1, 0);
        chk("t6_bank_taken", 32'(bank_free), 1);
        wait_done("t6", 2000);
        chk("t6_no_hdr", 32'(hdr_log.size()), 0);
        chk("t6_bank_free", 32'(bank_free), 3);

        // Reset in the middle of the payload
        push_line(1'b0, 200, 3, 2);
        do_line(1'b0, 200);
        base = nbytes;
        n = 0;
        while (nbytes < base + 30 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL t7_reach_pay got %0d bytes required %0d", nbytes - base, 30);
        end
        chk("t7_busy_mid", 32'(busy), 1);
        tr_mode = 2;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("t7_rst");
        rst = 1'b0;
        tr_mode = 0;
        @(posedge clk); #1;
        push_line(1'b1, 8, 0, 0);
        do_line(1'b1, 8);
        wait_done("t7", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
